// File: rtl/disp_pkg.sv
// Shared types and constants for the display frame arbiter.
package disp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    localparam int CHAR_W  = 4;
    localparam int FRAME_W = 16;

    // A frame viewed as its characters; index 0 is the rightmost digit.
    typedef logic [FRAME_W/CHAR_W-1:0][CHAR_W-1:0] frame_t;

    localparam logic [FRAME_W-1:0] RESET_FRAME = 16'h3210;

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that holds a granted frame on the display for a fixed time.
// Loaded with DWELL_CYCLES-1 on a grant; count_zero marks the last dwell cycle.
module dwell_timer #(
    parameter int DWELL_WIDTH  = 10,
    parameter int DWELL_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_b,
    input  logic load,
    input  logic hold,
    input  logic busy,
    output logic count_zero
);

    localparam logic [DWELL_WIDTH-1:0] LOAD_VAL = DWELL_WIDTH'(DWELL_CYCLES - 1);

    logic [DWELL_WIDTH-1:0] cnt;

    // Count down while dwelling; hold freezes, and the count parks at zero.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (busy && !hold && (cnt != '0)) begin
            cnt <= cnt - DWELL_WIDTH'(1);
        end
    end

    assign count_zero = (cnt == '0);

endmodule

// File: rtl/disp_arbiter.sv
// Two-requester round-robin arbiter for the display frame path.
// A granted frame stays on the display for DWELL_CYCLES cycles before the
// next grant can be taken.
//
//   state | meaning
//   IDLE  | frame retained, ready offered to the round-robin winner
//   DWELL | granted frame on display, timer counting, no ready
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int DWELL_WIDTH  = 10,
    parameter int DWELL_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               SYNC_DEBNC_RST_N,
    input  logic               req0_valid,
    input  logic [FRAME_W-1:0] req0_frame,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [FRAME_W-1:0] req1_frame,
    output logic               req1_ready,
    input  logic               hold,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_owner,
    output logic               frame_update,
    output logic               busy
);

    state_t state;
    state_t state_nxt;
    logic   grant;
    logic   xfer;
    logic   count_zero;
    logic   last_owner;
    logic   owner_q;
    logic   update_q;
    frame_t frame_q;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_owner;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign xfer = req0_ready | req1_ready;

    // State register.
    always_ff @(posedge clk or negedge SYNC_DEBNC_RST_N) begin
        if (!SYNC_DEBNC_RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a transfer starts a dwell; the dwell ends once the timer hits zero unheld.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = DWELL;
            DWELL:   if (!hold && count_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: ready only in IDLE, busy only in DWELL.
    always_comb begin
        req0_ready = (state == IDLE) && req0_valid && (grant == 1'b0);
        req1_ready = (state == IDLE) && req1_valid && (grant == 1'b1);
        busy       = (state == DWELL);
    end

    // Capture the granted frame and its owner; frame_update marks the cycle it appears.
    always_ff @(posedge clk or negedge SYNC_DEBNC_RST_N) begin
        if (!SYNC_DEBNC_RST_N) begin
            frame_q    <= frame_t'(RESET_FRAME);
            owner_q    <= 1'b0;
            last_owner <= 1'b1;
            update_q   <= 1'b0;
        end else begin
            update_q <= xfer;
            if (xfer) begin
                frame_q    <= req1_ready ? frame_t'(req1_frame) : frame_t'(req0_frame);
                owner_q    <= req1_ready;
                last_owner <= req1_ready;
            end
        end
    end

    assign frame        = frame_q;
    assign frame_owner  = owner_q;
    assign frame_update = update_q;

    dwell_timer #(
        .DWELL_WIDTH  (DWELL_WIDTH),
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .clk        (clk),
        .rst_b      (SYNC_DEBNC_RST_N),
        .load       (xfer),
        .hold       (hold),
        .busy       (busy),
        .count_zero (count_zero)
    );

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter with a short dwell, directed
// scenarios followed by random traffic, against a cycle-level model.
module tb_disp_arbiter;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_frame = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_frame = '0;
    logic        req1_ready;
    logic        hold = 1'b0;
    logic [15:0] frame;
    logic        frame_owner;
    logic        frame_update;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: cycles of dwell still to show, who went last, what is on display.
    int          m_left;
    bit          m_last;
    bit          m_owner;
    logic [15:0] m_frame;
    bit          m_upd;

    disp_arbiter #(
        .DWELL_WIDTH  (10),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk              (clk),
        .SYNC_DEBNC_RST_N (rst_n),
        .req0_valid       (req0_valid),
        .req0_frame       (req0_frame),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_frame       (req1_frame),
        .req1_ready       (req1_ready),
        .hold             (hold),
        .frame            (frame),
        .frame_owner      (frame_owner),
        .frame_update     (frame_update),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_last  = 1'b1;
        m_owner = 1'b0;
        m_frame = 16'h3210;
        m_upd   = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then advance the model.
    task automatic cycle(input bit v0, input logic [15:0] f0, input bit v1,
                         input logic [15:0] f1, input bit h, input bit rst);
        int win;
        @(negedge clk);
        req0_valid = v0;
        req0_frame = f0;
        req1_valid = v1;
        req1_frame = f1;
        hold       = h;
        rst_n      = ~rst;
        #1;
        if (rst) model_reset();
        win = -1;
        if (m_left == 0) begin
            if (v0 && v1)  win = m_last ? 0 : 1;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
        end
        chk("req0_ready",   {31'd0, req0_ready},   {31'd0, win == 0});
        chk("req1_ready",   {31'd0, req1_ready},   {31'd0, win == 1});
        chk("frame",        {16'd0, frame},        {16'd0, m_frame});
        chk("frame_owner",  {31'd0, frame_owner},  {31'd0, m_owner});
        chk("frame_update", {31'd0, frame_update}, {31'd0, m_upd});
        chk("busy",         {31'd0, busy},         {31'd0, m_left > 0});
        if (!rst) begin
            if (win >= 0) begin
                m_frame = (win == 0) ? f0 : f1;
                m_owner = (win == 1);
                m_last  = (win == 1);
                m_left  = DW;
                m_upd   = 1'b1;
            end else begin
                m_upd = 1'b0;
                if (m_left > 0 && !h) m_left--;
            end
        end
    endtask

    initial begin
        model_reset();

        // Reset, then idle with nothing requested.
        cycle(0, 16'h0, 0, 16'h0, 0, 1);
        cycle(0, 16'h0, 0, 16'h0, 0, 1);
        repeat (3) cycle(0, 16'h0, 0, 16'h0, 0, 0);

        // Single frame from requester 0, then a long quiet spell.
        cycle(1, 16'hABCD, 0, 16'h0, 0, 0);
        repeat (8) cycle(0, 16'h0, 0, 16'h0, 0, 0);
        chk("frame_kept", {16'd0, frame}, 32'h0000ABCD);

        // Both requesters streaming: alternating grants, one every DW+1 cycles.
        repeat (22) cycle(1, 16'h1111, 1, 16'h2222, 0, 0);
        repeat (6) cycle(0, 16'h0, 0, 16'h0, 0, 0);

        // Hold for three cycles mid-dwell with requester 1 waiting throughout.
        cycle(1, 16'h4444, 0, 16'h0, 0, 0);
        repeat (2) cycle(0, 16'h0, 1, 16'h5555, 0, 0);
        repeat (3) cycle(0, 16'h0, 1, 16'h5555, 1, 0);
        repeat (6) cycle(0, 16'h0, 1, 16'h5555, 0, 0);
        repeat (6) cycle(0, 16'h0, 0, 16'h0, 0, 0);

        // Reset in the middle of a dwell with both requesting; requester 0 must win after.
        cycle(0, 16'h0, 1, 16'h6666, 0, 0);
        repeat (2) cycle(1, 16'h5A5A, 1, 16'hA5A5, 0, 0);
        cycle(1, 16'h5A5A, 1, 16'hA5A5, 0, 1);
        cycle(1, 16'h5A5A, 1, 16'hA5A5, 0, 0);
        cycle(0, 16'h0, 0, 16'h0, 0, 0);
        chk("post_reset_owner", {31'd0, frame_owner}, 32'd0);
        chk("post_reset_frame", {16'd0, frame}, 32'h00005A5A);
        repeat (6) cycle(0, 16'h0, 0, 16'h0, 0, 0);

        // One-cycle valid pulse from requester 1 while dwelling: ignored.
        cycle(1, 16'h7777, 0, 16'h0, 0, 0);
        cycle(0, 16'h0, 0, 16'h0, 0, 0);
        cycle(0, 16'h0, 1, 16'h8888, 0, 0);
        repeat (6) cycle(0, 16'h0, 0, 16'h0, 0, 0);
        chk("pulse_frame", {16'd0, frame}, 32'h00007777);

        // Random traffic with occasional hold and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 1) == 1, 16'($urandom),
                  $urandom_range(0, 1) == 1, 16'($urandom),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The block SHALL have parameter DWELL_WIDTH, default 10, giving the width of the dwell counter.
REQ-002 The block SHALL have parameter DWELL_CYCLES, default 1023, giving the number of cycles a granted frame is held; legal range 1..2^DWELL_WIDTH-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port SYNC_DEBNC_RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req0_valid, input, 1 bit: requester 0 offers a frame.
REQ-006 The block SHALL have port req0_frame, input, 16 bits: four 4-bit chars; [15:12] is digit 3 and [3:0] is digit 0.
REQ-007 The block SHALL have port req0_ready, output, 1 bit: requester 0 transfer accepted this cycle.
REQ-008 The block SHALL have ports req1_valid (input, 1), req1_frame (input, 16) and req1_ready (output, 1), identical in meaning for requester 1.
REQ-009 The block SHALL have port hold, input, 1 bit: freezes the dwell countdown.
REQ-010 The block SHALL have port frame, output, 16 bits: the frame currently presented to the anode/char driver.
REQ-011 The block SHALL have port frame_owner, output, 1 bit: the index of the requester whose frame is shown.
REQ-012 The block SHALL have port frame_update, output, 1 bit: a one-cycle pulse in the cycle frame takes a new value.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in DWELL.

Function
REQ-014 The block SHALL implement two states, IDLE and DWELL.
REQ-015 In IDLE, grant selection SHALL be as follows: with only one valid requester, that requester wins; with both valid, the requester that is not last_owner wins (round-robin).
REQ-016 reqN_ready SHALL be combinational and equal to (state==IDLE) & reqN_valid & (grant==N); it SHALL never be high for both requesters in the same cycle, and SHALL be low in DWELL.
REQ-017 A transfer SHALL occur when reqN_valid & reqN_ready are both high at a rising edge.
REQ-018 On a transfer, at the next edge, the block SHALL set frame to reqN_frame, set frame_owner and last_owner to N, pulse frame_update high for that one cycle, go to DWELL, and load the counter with DWELL_CYCLES-1.
REQ-019 In DWELL with hold low, the counter SHALL decrement by 1 each cycle; when the counter reads 0, the next state SHALL be IDLE.
REQ-020 In DWELL with hold high, the counter and state SHALL be frozen; frame SHALL remain unchanged.
REQ-021 Consecutive transfers SHALL therefore be at least DWELL_CYCLES+1 cycles apart when hold stays low.
REQ-022 hold asserted in IDLE SHALL have no effect; grants proceed.
REQ-023 In IDLE with no valid requester, frame SHALL be retained unchanged indefinitely.
REQ-024 A requester deasserting valid before its ready is high SHALL be legal, and SHALL cause no transfer and no state change.
REQ-025 The block SHALL perform no arithmetic other than the counter decrement; the counter SHALL never underflow (the decrement is suppressed at 0).

Reset
REQ-026 While SYNC_DEBNC_RST_N is low, the block SHALL force: state IDLE, counter 0, frame 16'h3210, frame_owner 0, last_owner 1, frame_update 0, busy 0.
REQ-027 Reset asserted mid-DWELL SHALL abort the dwell immediately; the first grant after release SHALL follow REQ-015 with last_owner=1, so req0 wins a tie.
REQ-028 On reset, req0_ready and req1_ready SHALL go low only through the state being IDLE; they SHALL follow REQ-016 combinationally.

Structure
REQ-029 A shared package disp_pkg SHALL hold the state enum (IDLE, DWELL), CHAR_W=4, FRAME_W=16 and RESET_FRAME=16'h3210.
REQ-030 The dwell countdown SHALL be one sub-module, dwell_timer, with load, hold, count-zero and busy signals; all other logic SHALL be in disp_arbiter.

Verification
(All scenarios use DWELL_CYCLES=4.)
REQ-031 Reset then idle: frame=16'h3210, owner=0, busy=0, both ready low.
REQ-032 req0_valid with 16'hABCD at cycle 0: req0_ready=1 at cycle 0; frame=ABCD, frame_update=1 and busy=1 at cycle 1; busy falls after 4 dwell cycles; frame is still ABCD afterwards.
REQ-033 req0 and req1 held valid continuously with 16'h1111 and 16'h2222: grants alternate 0,1,0,1; frame_update pulses every 5 cycles.
REQ-034 hold=1 for 3 cycles mid-DWELL: the busy period extends from 4 to 7 cycles; no ready is asserted during it.
REQ-035 Reset asserted at dwell count 2 with both valid: after release, req0 wins, frame=req0_frame, owner=0.
REQ-036 req1_valid pulsed for one cycle while in DWELL: no transfer, frame unchanged, req1_ready never high.
